// File: rtl/inject_eject_sched.sv
// Per-router eject/inject scheduler: a round-robin eject winner, a round-robin inject grant
// into a free or just-ejected channel slot, and a local-injection starvation tracker.
module inject_eject_sched #(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_TAG_SIZE = 3,
  parameter int STARVE_LIMIT  = 8,
  parameter int CNT_W         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PORTS-1:0]     port_valid,
  input  logic [NUM_PORTS-1:0]     port_eject_req,
  input  logic                     eject_ready,
  input  logic                     inj_req,
  output logic                     inj_ready,
  output logic [NUM_PORTS-1:0]     injectGrant,
  output logic [PORT_TAG_SIZE-1:0] winningFlitPortTag,
  output logic                     winningFlitValid,
  output logic                     starve_flag,
  output logic [1:0]               dbg_state
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STARVE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [PTR_W-1:0]   eject_ptr_q, eject_ptr_d;
  logic [PTR_W-1:0]   inj_ptr_q, inj_ptr_d;

  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] free_slot;
  logic                 ej_found, inj_found;
  logic [PTR_W-1:0]     ej_idx, inj_idx;
  logic                 ej_fire, inj_fire;
  int                   ej_probe, inj_probe;

  assign cand = port_valid & port_eject_req;

  // Eject winner: first candidate at or after eject_ptr, wrapping.
  always_comb begin
    ej_found = 1'b0;
    ej_idx   = '0;
    ej_probe = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      ej_probe = (int'(eject_ptr_q) + k) % NUM_PORTS;
      if (!ej_found && cand[ej_probe]) begin
        ej_found = 1'b1;
        ej_idx   = PTR_W'(ej_probe);
      end
    end
  end

  assign ej_fire = ~reset & eject_ready & ej_found;

  // A slot being ejected this cycle can take the local flit in the same cycle.
  always_comb begin
    free_slot = ~port_valid;
    if (ej_fire) free_slot[ej_idx] = 1'b1;
  end

  always_comb begin
    inj_found = 1'b0;
    inj_idx   = '0;
    inj_probe = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      inj_probe = (int'(inj_ptr_q) + k) % NUM_PORTS;
      if (!inj_found && free_slot[inj_probe]) begin
        inj_found = 1'b1;
        inj_idx   = PTR_W'(inj_probe);
      end
    end
  end

  assign inj_fire = ~reset & inj_req & inj_found;

  always_comb begin
    winningFlitValid   = ej_fire;
    winningFlitPortTag = ej_fire ? PORT_TAG_SIZE'(ej_idx) : '0;
    injectGrant        = '0;
    if (inj_fire) injectGrant[inj_idx] = 1'b1;
    inj_ready          = inj_fire;
  end

  always_comb begin
    eject_ptr_d = eject_ptr_q;
    inj_ptr_d   = inj_ptr_q;
    if (ej_fire)  eject_ptr_d = PTR_W'((int'(ej_idx) + 1) % NUM_PORTS);
    if (inj_fire) inj_ptr_d   = PTR_W'((int'(inj_idx) + 1) % NUM_PORTS);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      eject_ptr_q  <= '0;
      inj_ptr_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      eject_ptr_q  <= eject_ptr_d;
      inj_ptr_q    <= inj_ptr_d;
    end
  end

  // Next-state logic; the counter saturates at STARVE_LIMIT and never wraps.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (inj_req && !inj_fire) begin
          starve_cnt_d = CNT_W'(1);
          state_d      = (STARVE_LIMIT <= 1) ? ST_STARVE : ST_WAIT;
        end else begin
          starve_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (inj_fire || !inj_req) begin
          state_d      = ST_IDLE;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
          if (starve_cnt_q + CNT_W'(1) == CNT_W'(STARVE_LIMIT)) state_d = ST_STARVE;
        end
      end
      ST_STARVE: begin
        if (inj_fire || !inj_req) begin
          state_d      = ST_IDLE;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = CNT_W'(STARVE_LIMIT);
        end
      end
      default: begin
        state_d      = ST_IDLE;
        starve_cnt_d = '0;
      end
    endcase
  end

  // Output decode of the registered state
  always_comb begin
    starve_flag = (state_q == ST_STARVE);
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_inject_eject_sched.sv
// Directed bench for inject_eject_sched: hand-computed eject tags, inject grants and
// starvation timing, checked at the falling edge after inputs settle.
module tb_inject_eject_sched;

  logic       clk;
  logic       reset;
  logic [3:0] port_valid;
  logic [3:0] port_eject_req;
  logic       eject_ready;
  logic       inj_req;
  logic       inj_ready;
  logic [3:0] injectGrant;
  logic [2:0] winningFlitPortTag;
  logic       winningFlitValid;
  logic       starve_flag;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  inject_eject_sched #(
    .NUM_PORTS(4), .PORT_TAG_SIZE(3), .STARVE_LIMIT(8), .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .port_valid(port_valid),
    .port_eject_req(port_eject_req),
    .eject_ready(eject_ready),
    .inj_req(inj_req),
    .inj_ready(inj_ready),
    .injectGrant(injectGrant),
    .winningFlitPortTag(winningFlitPortTag),
    .winningFlitValid(winningFlitValid),
    .starve_flag(starve_flag),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed hang, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: apply inputs just after a rising edge, return at the falling edge for sampling.
  task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] e,
                       input logic er, input logic ir);
    @(posedge clk);
    #1;
    reset          = rst;
    port_valid     = v;
    port_eject_req = e;
    eject_ready    = er;
    inj_req        = ir;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; port_valid = 4'hf; port_eject_req = 4'hf; eject_ready = 1'b1; inj_req = 1'b1;

    // Reset held with all inputs high: every output forced low.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1);
      check("rst_comb_outs", {23'd0, inj_ready, injectGrant, winningFlitPortTag, winningFlitValid}, 32'd0);
      check("rst_flag", {31'd0, starve_flag}, 32'd0);
    end
    // First cycle after release: both pointers at 0; only the ejected slot is free.
    drive(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1);
    check("post_rst_tag", {29'd0, winningFlitPortTag}, 32'd0);
    check("post_rst_valid", {31'd0, winningFlitValid}, 32'd1);
    check("post_rst_grant", {28'd0, injectGrant}, 32'h1);
    check("post_rst_inj_ready", {31'd0, inj_ready}, 32'd1);
    check("post_rst_state", {30'd0, dbg_state}, 32'd0);

    // Round-robin eject between ports 1 and 3.
    do_reset();
    exp_q.push_back(32'd1); exp_q.push_back(32'd3); exp_q.push_back(32'd1);
    while (exp_q.size() > 0) begin
      drive(1'b0, 4'b1111, 4'b1010, 1'b1, 1'b0);
      exp_v = exp_q.pop_front();
      check("rr_tag", {29'd0, winningFlitPortTag}, exp_v);
      check("rr_valid", {31'd0, winningFlitValid}, 32'd1);
      check("rr_no_grant", {28'd0, injectGrant}, 32'd0);
    end
    // Sink not ready: no eject, pointer (now 2) holds.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b1111, 4'b1010, 1'b0, 1'b0);
      check("notready_valid", {31'd0, winningFlitValid}, 32'd0);
      check("notready_tag", {29'd0, winningFlitPortTag}, 32'd0);
    end
    drive(1'b0, 4'b1111, 4'b1010, 1'b1, 1'b0);
    check("ptr_held_tag", {29'd0, winningFlitPortTag}, 32'd3);

    // Same-cycle reuse of the ejected slot.
    do_reset();
    drive(1'b0, 4'b1111, 4'b0100, 1'b1, 1'b1);
    check("reuse_tag", {29'd0, winningFlitPortTag}, 32'd2);
    check("reuse_valid", {31'd0, winningFlitValid}, 32'd1);
    check("reuse_grant", {28'd0, injectGrant}, 32'h4);
    check("reuse_inj_ready", {31'd0, inj_ready}, 32'd1);
    // inj_ptr now 3: free slots 0 and 3 -> 3 first, then wrap to 0.
    drive(1'b0, 4'b0110, 4'b0000, 1'b1, 1'b1);
    check("wrap_grant_3", {28'd0, injectGrant}, 32'h8);
    drive(1'b0, 4'b0110, 4'b0000, 1'b1, 1'b1);
    check("wrap_grant_0", {28'd0, injectGrant}, 32'h1);

    // Starvation: 8 denied cycles then flag; saturate; then grant clears it.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1);
      check("denied_grant", {28'd0, injectGrant}, 32'd0);
      check("denied_flag_low", {31'd0, starve_flag}, 32'd0);
      if (i == 3) check("wait_state", {30'd0, dbg_state}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1);
      check("starve_flag_high", {31'd0, starve_flag}, 32'd1);
    end
    drive(1'b0, 4'b1110, 4'b0000, 1'b1, 1'b1);
    check("starve_release_grant", {28'd0, injectGrant}, 32'h1);
    check("starve_flag_still", {31'd0, starve_flag}, 32'd1);
    drive(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0);
    check("starve_flag_cleared", {31'd0, starve_flag}, 32'd0);
    check("starve_idle", {30'd0, dbg_state}, 32'd0);

    // Reset in the middle of starvation drops the grant and clears the state.
    for (int i = 0; i < 9; i++) drive(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1);
    check("pre_midrst_flag", {31'd0, starve_flag}, 32'd1);
    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1);
    check("midrst_grant", {28'd0, injectGrant}, 32'd0);
    check("midrst_inj_ready", {31'd0, inj_ready}, 32'd0);
    drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
    check("midrst_flag", {31'd0, starve_flag}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);

    // All slots free: inject grant rotates.
    do_reset();
    exp_q.push_back(32'h1); exp_q.push_back(32'h2); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'h1);
    while (exp_q.size() > 0) begin
      drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      check("rotate_grant", {28'd0, injectGrant}, exp_v);
      check("rotate_flag", {31'd0, starve_flag}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
